// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial N-bit adder/subtractor, LSB first, one full-adder slice
module serial_add_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         c,
    output logic         v
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-2:0]  r_sr;
    logic [N-1:0]  r_full;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          fa_sum;
    logic          fa_cout;
    logic          last_bit;
    logic          accept;

    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_cout  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit = (cnt == CW'(N - 1));
    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    // After N-1 shifts r_sr holds the low result bits; the current sum bit completes the word.
    assign r_full   = {fa_sum, r_sr};

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (last_bit) state_next = S_DONE;
            S_DONE: state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1; the +1 enters through the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_full[N-1:1];
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                s <= r_full;
                c <= fa_cout;
                v <= carry ^ fa_cout;
            end
        end
    end
endmodule
